// File: rtl/qdec_cabac_dec_arb.sv
// Round-robin arbiter that shares one CABAC decoding engine among four requesters.
// It tracks bins still in flight so that ownership is released only after they return.
module qdec_cabac_dec_arb (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  req,
   input  logic [3:0]  done,
   input  logic [39:0] ctx_addr_i,
   input  logic [3:0]  ctx_addr_vld_i,
   input  logic [3:0]  dec_run_i,
   input  logic [3:0]  EPMode_i,
   output logic [9:0]  ctx_addr,
   output logic        ctx_addr_vld,
   output logic        dec_run,
   output logic        EPMode,
   input  logic        dec_rdy,
   input  logic        ruiBin,
   input  logic        ruiBin_vld,
   output logic [3:0]  ruiBin_vld_o,
   output logic        ruiBin_o,
   output logic [3:0]  grant,
   output logic        busy,
   output logic        err_viol
);

   // state   | meaning
   // S_IDLE  | no owner; round-robin pick from rr_ptr when any req is high
   // S_GRANT | owner latched, one-cycle handoff before traffic is accepted
   // S_OWN   | owner's strobes are forwarded to the engine
   // S_DRAIN | owner is done, waiting for outstanding bins and engine ready
   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_OWN, S_DRAIN} state_t;

   state_t      state_q, state_d;
   logic [1:0]  owner_q, owner_d;
   logic [1:0]  rr_ptr_q, rr_ptr_d;
   logic [2:0]  outstanding_q;
   logic [1:0]  winner;
   logic [1:0]  idx;
   logic [3:0]  owner_oh;
   logic [9:0]  sel_addr;
   logic        in_own;
   logic        cnt_inc;
   logic        cnt_dec;
   logic        viol;

   assign owner_oh = 4'b0001 << owner_q;
   assign in_own   = (state_q == S_OWN);
   assign grant    = (state_q != S_IDLE) ? owner_oh : 4'b0000;
   assign busy     = (state_q != S_IDLE);
   assign ruiBin_o = ruiBin;
   assign ruiBin_vld_o = ((state_q == S_OWN) || (state_q == S_DRAIN)) ?
                         ({3'b000, ruiBin_vld} << owner_q) : 4'b0000;

   // Descending scan so the requester closest to rr_ptr is the last assignment.
   always_comb begin
      winner = rr_ptr_q;
      idx    = rr_ptr_q;
      for (int i = 3; i >= 0; i--) begin
         idx = rr_ptr_q + 2'(i);
         if (req[idx]) winner = idx;
      end
   end

   always_comb begin
      sel_addr = ctx_addr_i[9:0];
      case (owner_q)
         2'd0: sel_addr = ctx_addr_i[9:0];
         2'd1: sel_addr = ctx_addr_i[19:10];
         2'd2: sel_addr = ctx_addr_i[29:20];
         2'd3: sel_addr = ctx_addr_i[39:30];
         default: sel_addr = ctx_addr_i[9:0];
      endcase
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               owner_d = winner;
               state_d = S_GRANT;
            end
         end
         S_GRANT: state_d = S_OWN;
         S_OWN: begin
            if (done[owner_q]) begin
               if (outstanding_q == 3'd0) begin
                  state_d  = S_IDLE;
                  rr_ptr_d = owner_q + 2'd1;
               end else begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if ((outstanding_q == 3'd0) && dec_rdy) begin
               state_d  = S_IDLE;
               rr_ptr_d = owner_q + 2'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         owner_q  <= 2'd0;
         rr_ptr_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctx_addr     <= 10'd0;
         ctx_addr_vld <= 1'b0;
         dec_run      <= 1'b0;
         EPMode       <= 1'b0;
      end else if (in_own) begin
         ctx_addr     <= sel_addr;
         ctx_addr_vld <= ctx_addr_vld_i[owner_q];
         dec_run      <= dec_run_i[owner_q];
         EPMode       <= EPMode_i[owner_q];
      end else begin
         ctx_addr_vld <= 1'b0;
         dec_run      <= 1'b0;
      end
   end

   // The counter follows the registered run strobe, i.e. what the engine actually saw.
   assign cnt_inc = dec_run;
   assign cnt_dec = ruiBin_vld;
   assign viol = (|((dec_run_i | ctx_addr_vld_i) & ~grant))
               | (ruiBin_vld && (outstanding_q == 3'd0))
               | (cnt_inc && !cnt_dec && (outstanding_q == 3'd7));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding_q <= 3'd0;
         err_viol      <= 1'b0;
      end else begin
         if (cnt_inc && !cnt_dec && (outstanding_q != 3'd7))
            outstanding_q <= outstanding_q + 3'd1;
         else if (cnt_dec && !cnt_inc && (outstanding_q != 3'd0))
            outstanding_q <= outstanding_q - 3'd1;
         err_viol <= err_viol | viol;
      end
   end

endmodule

// File: doc/qdec_cabac_dec_arb.md
QDEC_CABAC_DEC_ARB -- requirements
Module: qdec_cabac_dec_arb

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low: clk (input, 1), rising-edge clock; rst_n (input, 1), async active-low reset.
REQ-002 SHALL have port: req  input  4  per-requester decode request, level held until its done pulse; index 0=cqt/cu, 1=pu, 2=tu, 3=sao.
REQ-003 SHALL have port: done  input  4  per-requester done_intr pulse, 1 cycle.
REQ-004 SHALL have port: ctx_addr_i  input  40  four packed 10-bit context addresses, requester k at bits [10k+9:10k].
REQ-005 SHALL have port: ctx_addr_vld_i  input  4  per-requester context-address valid.
REQ-006 SHALL have port: dec_run_i  input  4  per-requester decode-run strobe.
REQ-007 SHALL have port: EPMode_i  input  4  per-requester bypass-mode select.
REQ-008 SHALL have port: ctx_addr  output  10  context address to the shared decoding engine.
REQ-009 SHALL have port: ctx_addr_vld  output  1  valid for ctx_addr.
REQ-010 SHALL have port: dec_run  output  1  decode-run strobe to the engine.
REQ-011 SHALL have port: EPMode  output  1  bypass mode to the engine.
REQ-012 SHALL have port: dec_rdy  input  1  engine ready.
REQ-013 SHALL have port: ruiBin  input  1  decoded bin from the engine.
REQ-014 SHALL have port: ruiBin_vld  input  1  decoded-bin valid from the engine.
REQ-015 SHALL have port: ruiBin_vld_o  output  4  bin valid routed to the owner only.
REQ-016 SHALL have port: ruiBin_o  output  1  broadcast copy of ruiBin.
REQ-017 SHALL have port: grant  output  4  one-hot owner indication; all zero when no owner.
REQ-018 SHALL have port: busy  output  1  high whenever the state is not IDLE.
REQ-019 SHALL have port: err_viol  output  1  sticky protocol-violation flag.

Function
REQ-020 SHALL implement states IDLE, GRANT, OWN and DRAIN.
REQ-021 IDLE: when any req is high, the arbiter SHALL select a winner by round-robin starting at rr_ptr, latch owner, and go to GRANT; with no req it SHALL stay in IDLE.
REQ-022 GRANT SHALL last exactly 1 cycle, with grant[owner]=1 from this cycle on, then go to OWN.
REQ-023 OWN: when done[owner] is seen and outstanding==0, the arbiter SHALL go to IDLE; when done[owner] is seen and outstanding>0, it SHALL go to DRAIN.
REQ-024 DRAIN: the arbiter SHALL go to IDLE when outstanding==0 and dec_rdy==1.
REQ-025 On leaving to IDLE, the arbiter SHALL set rr_ptr=(owner+1) mod 4 and grant SHALL go to 0 in the same cycle that IDLE is entered.
REQ-026 In OWN, ctx_addr, ctx_addr_vld, dec_run and EPMode SHALL be registered copies of the owner's inputs, 1-cycle latency; outside OWN, the valid/run outputs SHALL be 0 and ctx_addr/EPMode SHALL hold their values.
REQ-027 ruiBin_vld_o[owner] SHALL equal ruiBin_vld combinationally in OWN and DRAIN; all other bits SHALL be 0.
REQ-028 A 3-bit outstanding counter SHALL count +1 per dec_run output cycle and -1 per ruiBin_vld; on a simultaneous increment and decrement it SHALL hold; it SHALL saturate at 7 and not underflow below 0.
REQ-029 err_viol SHALL set on any of: dec_run_i or ctx_addr_vld_i from a non-owner; ruiBin_vld with outstanding==0; counter overflow; it SHALL clear only on reset.
REQ-030 A done pulse from a non-owner SHALL be ignored.
REQ-031 A req dropped by the owner before its done pulse SHALL have no effect on the state.
REQ-032 A request arriving on the same cycle the owner releases SHALL be arbitrated at the next IDLE cycle, so re-grant takes at least 1 IDLE cycle.

Reset
REQ-033 On rst_n=0 the block SHALL asynchronously go to IDLE with rr_ptr=0, owner=0, outstanding=0, grant=0, busy=0, ctx_addr=0, ctx_addr_vld=0, dec_run=0, EPMode=0, ruiBin_vld_o=0, err_viol=0.
REQ-034 A reset mid-OWN SHALL discard the transaction; no stale ruiBin_vld_o SHALL be routed after reset is released.

Verification
REQ-035 Bench SHALL cover: req=4'b0010 at reset exit -> grant=0010 within 2 cycles; dec_run_i[1] pulse -> dec_run=1 one cycle later; ruiBin_vld -> ruiBin_vld_o=0010.
REQ-036 Bench SHALL cover: req=4'b1111 held, each owner doing one bin then done -> grant sequence 0001, 0010, 0100, 1000, 0001.
REQ-037 Bench SHALL cover: owner 2 issues 2 dec_run, then done before any bin returns -> DRAIN; after 2 ruiBin_vld with dec_rdy=1 -> IDLE and grant=0.
REQ-038 Bench SHALL cover: dec_run_i[3] pulse while owner=0 -> err_viol=1 and dec_run stays 0; err_viol held until reset.
REQ-039 Bench SHALL cover: async rst_n low mid-OWN with outstanding=3 -> all outputs 0 immediately; after release with req=0001 -> grant=0001 and outstanding=0.
REQ-040 Bench SHALL cover: done[1] while owner=0 -> ignored, state remains OWN with grant=0001.
